// File: rtl/register_bank_burst_if.sv
// Bus bundle for register_bank_burst: read/write ports, burst-load stream, taps.
// Master drives addresses, data and handshake requests; slave is the register bank.
interface register_bank_burst_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_TAPS = 3
) ();
  logic [ADDR_W-1:0]          dir_a;
  logic [ADDR_W-1:0]          dir_b;
  logic                       re_a_n;
  logic                       re_b_n;
  logic                       we_n;
  logic [ADDR_W-1:0]          dir_wr;
  logic [DATA_W-1:0]          di;
  logic                       burst_start;
  logic [ADDR_W-1:0]          burst_base;
  logic [ADDR_W:0]            burst_len;
  logic                       burst_valid;
  logic                       burst_ready;
  logic                       burst_busy;
  logic                       burst_done;
  logic                       wr_conflict;
  logic [DATA_W-1:0]          data_a;
  logic [DATA_W-1:0]          data_b;
  logic [NUM_TAPS*DATA_W-1:0] taps;
  logic [1:0]                 dbg_state;

  modport master (
    output dir_a, dir_b, re_a_n, re_b_n, we_n, dir_wr, di,
           burst_start, burst_base, burst_len, burst_valid,
    input  burst_ready, burst_busy, burst_done, wr_conflict,
           data_a, data_b, taps, dbg_state
  );

  modport slave (
    input  dir_a, dir_b, re_a_n, re_b_n, we_n, dir_wr, di,
           burst_start, burst_base, burst_len, burst_valid,
    output burst_ready, burst_busy, burst_done, wr_conflict,
           data_a, data_b, taps, dbg_state
  );
endinterface

// File: rtl/register_bank_burst.sv
// DEPTH-entry register file with two registered read ports, one single-word write
// port, a burst-load engine for coefficient streams, and the low registers exported as taps.
module register_bank_burst #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_TAPS = 3
) (
  input logic                  clk,
  input logic                  rst,
  register_bank_burst_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_cnt;
  logic [DATA_W-1:0]   r_data_a;
  logic [DATA_W-1:0]   r_data_b;
  logic                r_wr_conflict;
  logic                w_single_wr;
  logic                w_burst_wr;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_ready;
  logic                w_busy;
  logic                w_done;

  // Burst handshake: a beat on di is written when burst_valid and burst_ready are
  // both high at a rising edge; burst_valid low in LOAD is a stall, burst_ready only
  // depends on state so the source may hold or change di freely while stalled.
  assign w_single_wr = !bus.we_n && (r_state == S_IDLE);
  assign w_burst_wr  = (r_state == S_LOAD) && bus.burst_valid;
  assign w_wr_en     = w_single_wr || w_burst_wr;
  assign w_wr_addr   = w_burst_wr ? r_ptr : bus.dir_wr;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.burst_start)
          w_next = (bus.burst_len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (bus.burst_valid && (r_cnt == (ADDR_W+1)'(1)))
          w_next = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_wr_conflict <= !bus.we_n && (r_state != S_IDLE);
      if ((r_state == S_IDLE) && bus.burst_start) begin
        r_ptr <= bus.burst_base;
        r_cnt <= bus.burst_len;
      end else if (w_burst_wr) begin
        r_ptr <= r_ptr + ADDR_W'(1);
        r_cnt <= r_cnt - (ADDR_W+1)'(1);
      end
    end
  end

  // Reads bypass a write landing on the same address at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      if (w_wr_en) r_mem[w_wr_addr] <= bus.di;
      if (!bus.re_a_n)
        r_data_a <= (w_wr_en && (w_wr_addr == bus.dir_a)) ? bus.di : r_mem[bus.dir_a];
      if (!bus.re_b_n)
        r_data_b <= (w_wr_en && (w_wr_addr == bus.dir_b)) ? bus.di : r_mem[bus.dir_b];
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
    assign bus.taps[g*DATA_W +: DATA_W] = r_mem[g];
  end

  assign bus.burst_ready = w_ready;
  assign bus.burst_busy  = w_busy;
  assign bus.burst_done  = w_done;
  assign bus.wr_conflict = r_wr_conflict;
  assign bus.data_a      = r_data_a;
  assign bus.data_b      = r_data_b;
  assign bus.dbg_state   = r_state;
endmodule
